// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants: opcodes, the canonical NOP and immediate formats,
// plus helpers that classify an opcode's operand usage and immediate format.
package riscv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_e;

    function automatic imm_type_e imm_type_of(input logic [6:0] opcode);
        imm_type_e t;
        case (opcode)
            OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: t = IMM_I;
            OP_STORE:                            t = IMM_S;
            OP_BRANCH:                           t = IMM_B;
            OP_LUI, OP_AUIPC:                    t = IMM_U;
            OP_JAL:                              t = IMM_J;
            default:                             t = IMM_NONE;
        endcase
        return t;
    endfunction

    // Only the upper-immediate and JAL forms ignore rs1; undefined opcodes are
    // treated as using it so a hazard is never missed.
    function automatic logic uses_rs1(input logic [6:0] opcode);
        return !(opcode == OP_LUI || opcode == OP_AUIPC || opcode == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_R || opcode == OP_STORE || opcode == OP_BRANCH);
    endfunction

endpackage

// File: rtl/stageid_regfile.sv
// 32x32 architectural register file: two combinational read ports, one write port,
// x0 hard-wired to zero, and same-cycle write-back bypass on both read ports.
module regfile
    import riscv_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  raddr1_i,
    input  logic [4:0]  raddr2_i,
    output logic [31:0] rdata1_o,
    output logic [31:0] rdata2_o
);

    logic [31:0] regs_q [32];
    logic        wr_en;

    assign wr_en = we_i && (waddr_i != 5'd0);

    // Entry 0 is cleared by reset and never written; the read path forces zero anyway.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    logic [4:0]  raddr [2];
    logic [31:0] rdata [2];

    assign raddr[0] = raddr1_i;
    assign raddr[1] = raddr2_i;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rport
            always_comb begin
                rdata[gi] = regs_q[raddr[gi]];
                if (raddr[gi] == 5'd0) begin
                    rdata[gi] = '0;
                end else if (wr_en && (waddr_i == raddr[gi])) begin
                    rdata[gi] = wdata_i;
                end
            end
        end
    endgenerate

    assign rdata1_o = rdata[0];
    assign rdata2_o = rdata[1];

endmodule

// File: rtl/stageid.sv
// RV32I decode stage: IF/ID pipeline register, register-file read with bypass,
// load-use hazard detection and immediate generation.
module stageid
    import riscv_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_pc_four,
    input  logic        i_pc_sel_ex,
    input  logic        i_ex_mem_read,
    input  logic [4:0]  i_ex_rd,
    input  logic        i_wb_we,
    input  logic [4:0]  i_wb_rd,
    input  logic [31:0] i_wb_data,
    output logic        o_stall_if,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_four,
    output logic [31:0] o_instr,
    output logic [4:0]  o_rs1,
    output logic [4:0]  o_rs2,
    output logic [4:0]  o_rd,
    output logic [31:0] o_rs1_data,
    output logic [31:0] o_rs2_data,
    output logic [31:0] o_imm
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_four_q, pc_four_d;
    logic [31:0] instr_q, instr_d;

    logic [6:0]  opcode;
    logic [4:0]  rs1_f, rs2_f, rd_f;
    logic        stall;

    assign opcode = instr_q[6:0];
    assign rs1_f  = instr_q[19:15];
    assign rs2_f  = instr_q[24:20];
    assign rd_f   = instr_q[11:7];

    assign stall = valid_q && i_ex_mem_read && (i_ex_rd != 5'd0) &&
                   ((uses_rs1(opcode) && (i_ex_rd == rs1_f)) ||
                    (uses_rs2(opcode) && (i_ex_rd == rs2_f)));

    // A redirect from EX squashes the IF/ID contents even while stalled.
    always_comb begin
        valid_d   = valid_q;
        pc_d      = pc_q;
        pc_four_d = pc_four_q;
        instr_d   = instr_q;
        if (i_pc_sel_ex) begin
            valid_d   = 1'b0;
            pc_d      = '0;
            pc_four_d = '0;
            instr_d   = NOP;
        end else if (!stall) begin
            valid_d   = 1'b1;
            pc_d      = i_pc;
            pc_four_d = i_pc_four;
            instr_d   = i_instr;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            valid_q   <= 1'b0;
            pc_q      <= '0;
            pc_four_q <= '0;
            instr_q   <= NOP;
        end else begin
            valid_q   <= valid_d;
            pc_q      <= pc_d;
            pc_four_q <= pc_four_d;
            instr_q   <= instr_d;
        end
    end

    regfile u_regfile (
        .clk_i    (i_clk),
        .rst_i    (i_reset),
        .we_i     (i_wb_we),
        .waddr_i  (i_wb_rd),
        .wdata_i  (i_wb_data),
        .raddr1_i (rs1_f),
        .raddr2_i (rs2_f),
        .rdata1_o (o_rs1_data),
        .rdata2_o (o_rs2_data)
    );

    imm_type_e imm_type;
    logic [31:0] imm;

    assign imm_type = imm_type_of(opcode);

    always_comb begin
        imm = '0;
        case (imm_type)
            IMM_I:   imm = {{20{instr_q[31]}}, instr_q[31:20]};
            IMM_S:   imm = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
            IMM_B:   imm = {{19{instr_q[31]}}, instr_q[31], instr_q[7],
                            instr_q[30:25], instr_q[11:8], 1'b0};
            IMM_U:   imm = {instr_q[31:12], 12'b0};
            IMM_J:   imm = {{11{instr_q[31]}}, instr_q[31], instr_q[19:12],
                            instr_q[20], instr_q[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

    assign o_stall_if = stall;
    assign o_valid    = valid_q && !stall;
    assign o_pc       = pc_q;
    assign o_pc_four  = pc_four_q;
    assign o_instr    = instr_q;
    assign o_rs1      = rs1_f;
    assign o_rs2      = rs2_f;
    assign o_rd       = rd_f;
    assign o_imm      = imm;

endmodule

// File: tb/tb_stageid.sv
// Directed bench for stageid: stimulus pushes expected decode results into a
// scoreboard queue, a monitor pops and compares them mid-cycle.
module tb_stageid;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_instr;
    logic [31:0] i_pc;
    logic [31:0] i_pc_four;
    logic        i_pc_sel_ex;
    logic        i_ex_mem_read;
    logic [4:0]  i_ex_rd;
    logic        i_wb_we;
    logic [4:0]  i_wb_rd;
    logic [31:0] i_wb_data;
    logic        o_stall_if;
    logic        o_valid;
    logic [31:0] o_pc;
    logic [31:0] o_pc_four;
    logic [31:0] o_instr;
    logic [4:0]  o_rs1;
    logic [4:0]  o_rs2;
    logic [4:0]  o_rd;
    logic [31:0] o_rs1_data;
    logic [31:0] o_rs2_data;
    logic [31:0] o_imm;

    stageid dut (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_instr       (i_instr),
        .i_pc          (i_pc),
        .i_pc_four     (i_pc_four),
        .i_pc_sel_ex   (i_pc_sel_ex),
        .i_ex_mem_read (i_ex_mem_read),
        .i_ex_rd       (i_ex_rd),
        .i_wb_we       (i_wb_we),
        .i_wb_rd       (i_wb_rd),
        .i_wb_data     (i_wb_data),
        .o_stall_if    (o_stall_if),
        .o_valid       (o_valid),
        .o_pc          (o_pc),
        .o_pc_four     (o_pc_four),
        .o_instr       (o_instr),
        .o_rs1         (o_rs1),
        .o_rs2         (o_rs2),
        .o_rd          (o_rd),
        .o_rs1_data    (o_rs1_data),
        .o_rs2_data    (o_rs2_data),
        .o_imm         (o_imm)
    );

    always #5 i_clk = ~i_clk;

    // Mask bits: 0 valid, 1 stall, 2 pc, 3 instr, 4 rd, 5 imm, 6 rs1_data, 7 rs2_data
    localparam logic [7:0] M_V   = 8'h01;
    localparam logic [7:0] M_S   = 8'h02;
    localparam logic [7:0] M_PC  = 8'h04;
    localparam logic [7:0] M_IN  = 8'h08;
    localparam logic [7:0] M_RD  = 8'h10;
    localparam logic [7:0] M_IMM = 8'h20;
    localparam logic [7:0] M_R1  = 8'h40;
    localparam logic [7:0] M_R2  = 8'h80;

    localparam logic [31:0] NOP_I      = 32'h00000013;
    localparam logic [31:0] ADDI_X1_5  = 32'h00500093;
    localparam logic [31:0] ADD_4_3_3  = 32'h00318233;
    localparam logic [31:0] ADD_7_3_0  = 32'h000183B3;
    localparam logic [31:0] ADD_8_0_0  = 32'h00000433;
    localparam logic [31:0] ADD_6_5_0  = 32'h00028333;
    localparam logic [31:0] LUI_5      = 32'h123452B7;
    localparam logic [31:0] BEQ_M4     = 32'hFE000EE3;
    localparam logic [31:0] JAL_2048   = 32'h0010006F;
    localparam logic [31:0] SW_M1      = 32'hFE002FA3;

    typedef struct {
        string       name;
        logic [7:0]  mask;
        logic        valid;
        logic        stall;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] r1;
        logic [31:0] r2;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   step     = 0;
    bit   stim_done = 1'b0;

    task automatic push(input string name, input logic [7:0] mask,
                        input logic v, input logic s,
                        input logic [31:0] pc, input logic [31:0] instr,
                        input logic [4:0] rd, input logic [31:0] imm,
                        input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        e.name = name; e.mask = mask; e.valid = v; e.stall = s;
        e.pc = pc; e.instr = instr; e.rd = rd; e.imm = imm; e.r1 = r1; e.r2 = r2;
        sb.push_back(e);
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
    task automatic drive_step(input logic [31:0] instr);
        @(posedge i_clk);
        #1;
        i_instr   = instr;
        i_pc      = 32'h10 + 32'(step) * 4;
        i_pc_four = i_pc + 32'd4;
        step++;
    endtask

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", nm, act, req);
        end
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge i_clk);
            while (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.mask[0]) chk({e.name, ".valid"},    32'(o_valid),    32'(e.valid));
                if (e.mask[1]) chk({e.name, ".stall"},    32'(o_stall_if), 32'(e.stall));
                if (e.mask[2]) chk({e.name, ".pc"},       o_pc,            e.pc);
                if (e.mask[3]) chk({e.name, ".instr"},    o_instr,         e.instr);
                if (e.mask[4]) chk({e.name, ".rd"},       32'(o_rd),       32'(e.rd));
                if (e.mask[5]) chk({e.name, ".imm"},      o_imm,           e.imm);
                if (e.mask[6]) chk({e.name, ".rs1_data"}, o_rs1_data,      e.r1);
                if (e.mask[7]) chk({e.name, ".rs2_data"}, o_rs2_data,      e.r2);
                $display("txn %-14s instr=%h pc=%h valid=%0b stall=%0b imm=%h rs1d=%h rs2d=%h",
                         e.name, o_instr, o_pc, o_valid, o_stall_if, o_imm, o_rs1_data, o_rs2_data);
            end
        end
    end

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: stimulus did not complete (actual running, required done)");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        i_reset = 1'b1; i_instr = NOP_I; i_pc = '0; i_pc_four = '0;
        i_pc_sel_ex = 1'b0; i_ex_mem_read = 1'b0; i_ex_rd = '0;
        i_wb_we = 1'b0; i_wb_rd = '0; i_wb_data = '0;

        @(posedge i_clk); #1;
        push("reset", M_V | M_S | M_PC | M_IN, 1'b0, 1'b0, 32'h0, NOP_I, 5'd0, 32'h0, 32'h0, 32'h0);

        drive_step(ADDI_X1_5);
        i_reset = 1'b0;
        push("post_reset", M_V | M_S | M_IN, 1'b0, 1'b0, 32'h0, NOP_I, 5'd0, 32'h0, 32'h0, 32'h0);

        drive_step(ADD_4_3_3);
        push("addi", M_V | M_S | M_PC | M_RD | M_IMM | M_R1, 1'b1, 1'b0, 32'h10, ADDI_X1_5,
             5'd1, 32'd5, 32'h0, 32'h0);

        drive_step(ADD_7_3_0);
        i_wb_we = 1'b1; i_wb_rd = 5'd3; i_wb_data = 32'hDEADBEEF;
        push("bypass", M_V | M_RD | M_R1 | M_R2, 1'b1, 1'b0, 32'h0, 32'h0,
             5'd4, 32'h0, 32'hDEADBEEF, 32'hDEADBEEF);

        drive_step(ADD_8_0_0);
        i_wb_we = 1'b1; i_wb_rd = 5'd0; i_wb_data = 32'h12345678;
        push("storage_x0wr", M_RD | M_R1 | M_R2, 1'b1, 1'b0, 32'h0, 32'h0,
             5'd7, 32'h0, 32'hDEADBEEF, 32'h0);

        drive_step(ADD_6_5_0);
        i_wb_we = 1'b0;
        push("x0_read", M_RD | M_IMM | M_R1 | M_R2, 1'b1, 1'b0, 32'h0, 32'h0,
             5'd8, 32'h0, 32'h0, 32'h0);

        drive_step(LUI_5);
        i_ex_mem_read = 1'b1; i_ex_rd = 5'd5;
        push("load_use", M_V | M_S | M_PC | M_IN, 1'b0, 1'b1, 32'h20, ADD_6_5_0,
             5'd0, 32'h0, 32'h0, 32'h0);

        drive_step(LUI_5);
        i_ex_mem_read = 1'b0;
        push("stall_release", M_V | M_S | M_PC | M_IN, 1'b1, 1'b0, 32'h20, ADD_6_5_0,
             5'd0, 32'h0, 32'h0, 32'h0);

        drive_step(ADD_6_5_0);
        i_ex_mem_read = 1'b1; i_ex_rd = 5'd5;
        push("lui_no_stall", M_V | M_S | M_PC | M_RD | M_IMM, 1'b1, 1'b0, 32'h28, LUI_5,
             5'd5, 32'h12345000, 32'h0, 32'h0);

        drive_step(BEQ_M4);
        i_pc_sel_ex = 1'b1;
        push("flush_stall", M_V | M_S | M_IN, 1'b0, 1'b1, 32'h0, ADD_6_5_0,
             5'd0, 32'h0, 32'h0, 32'h0);

        drive_step(BEQ_M4);
        i_pc_sel_ex = 1'b0; i_ex_mem_read = 1'b0; i_ex_rd = 5'd0;
        push("flushed", M_V | M_S | M_PC | M_IN, 1'b0, 1'b0, 32'h0, NOP_I,
             5'd0, 32'h0, 32'h0, 32'h0);

        drive_step(JAL_2048);
        push("beq_imm", M_V | M_IN | M_IMM, 1'b1, 1'b0, 32'h0, BEQ_M4,
             5'd0, 32'hFFFFFFFC, 32'h0, 32'h0);

        drive_step(SW_M1);
        push("jal_imm", M_V | M_IN | M_IMM, 1'b1, 1'b0, 32'h0, JAL_2048,
             5'd0, 32'h00000800, 32'h0, 32'h0);

        drive_step(ADD_7_3_0);
        push("sw_imm", M_V | M_IN | M_IMM, 1'b1, 1'b0, 32'h0, SW_M1,
             5'd0, 32'hFFFFFFFF, 32'h0, 32'h0);

        drive_step(ADD_7_3_0);
        i_reset = 1'b1;
        push("async_reset", M_V | M_S | M_PC | M_IN, 1'b0, 1'b0, 32'h0, NOP_I,
             5'd0, 32'h0, 32'h0, 32'h0);

        drive_step(ADD_7_3_0);
        i_reset = 1'b0;
        push("reset_release", M_V | M_IN, 1'b0, 1'b0, 32'h0, NOP_I,
             5'd0, 32'h0, 32'h0, 32'h0);

        drive_step(NOP_I);
        push("rf_cleared", M_V | M_RD | M_R1 | M_R2, 1'b1, 1'b0, 32'h0, 32'h0,
             5'd7, 32'h0, 32'h0, 32'h0);

        repeat (2) @(negedge i_clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        stim_done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
